calc1_responder: RTL and testbench

CALC1_RESPONDER -- requirements
Module: calc1_responder

---
 rtl/calc1_pkg.sv | 37 +++
 rtl/calc1_alu.sv | 54 +++++
 rtl/calc1_responder.sv | 124 ++++++++++++
 tb/tb_calc1_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared encodings and helpers for the calc1 responder.
// Command/response codes, FSM state type, round-robin pick.
package calc1_pkg;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_LSH = 4'd5;
   localparam logic [3:0] CMD_RSH = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OP2,
      ST_WAIT,
      ST_RESP
   } state_t;

   // Returns {valid, index}; index ptr has highest priority.
   function automatic logic [2:0] rr_pick(
      input logic [3:0] req,
      input logic [1:0] ptr
   );
      logic [1:0] j;
      rr_pick = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         j = ptr + 2'(k);
         if (req[j]) begin
            rr_pick = {1'b1, j};
         end
      end
   endfunction

endpackage

// File: rtl/calc1_alu.sv
// Combinational datapath shared by all calc1 ports.
// Overflow, underflow and unknown commands report RESP_ERR with zero data.
module calc1_alu
   import calc1_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        cmd,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   output logic [1:0]        resp,
   output logic [DATA_W-1:0] data
);

   localparam int SH_W = $clog2(DATA_W);

   logic [DATA_W:0]   sum;
   logic [SH_W-1:0]   sh;

   assign sum = {1'b0, op1} + {1'b0, op2};
   assign sh  = op2[SH_W-1:0];

   always_comb begin
      resp = RESP_ERR;
      data = '0;
      unique case (1'b1)
         cmd == CMD_ADD: begin
            if (!sum[DATA_W]) begin
               resp = RESP_OK;
               data = sum[DATA_W-1:0];
            end
         end
         cmd == CMD_SUB: begin
            if (op2 <= op1) begin
               resp = RESP_OK;
               data = op1 - op2;
            end
         end
         cmd == CMD_LSH: begin
            resp = RESP_OK;
            data = op1 << sh;
         end
         cmd == CMD_RSH: begin
            resp = RESP_OK;
            data = op1 >> sh;
         end
         default: begin
            resp = RESP_ERR;
            data = '0;
         end
      endcase
   end

endmodule

// File: rtl/calc1_responder.sv
// Four-port calculator responder: per-port FSMs sharing one ALU.
// Ports in OP2 or WAIT contend round-robin for the ALU each cycle.
module calc1_responder
   import calc1_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32
) (
   input  logic              c_clk,
   input  logic [1:7]        reset,
   input  logic [0:3]        req_cmd_in  [1:NUM_PORTS],
   input  logic [0:DATA_W-1] req_data_in [1:NUM_PORTS],
   output logic [0:1]        out_resp    [1:NUM_PORTS],
   output logic [0:DATA_W-1] out_data    [1:NUM_PORTS]
);

   logic rst;
   logic unused_rst;

   assign rst        = reset[1];
   assign unused_rst = ^reset[2:7];

   logic [3:0]        cmd_in [NUM_PORTS];
   logic [DATA_W-1:0] dat_in [NUM_PORTS];

   state_t            st     [NUM_PORTS];
   logic [3:0]        cmd_q  [NUM_PORTS];
   logic [DATA_W-1:0] op1_q  [NUM_PORTS];
   logic [DATA_W-1:0] op2_q  [NUM_PORTS];
   logic [1:0]        resp_q [NUM_PORTS];
   logic [DATA_W-1:0] data_q [NUM_PORTS];

   logic [3:0]        req;
   logic [1:0]        ptr;
   logic [2:0]        pick;
   logic              gnt_any;
   logic [1:0]        gnt_idx;

   logic [3:0]        alu_cmd;
   logic [DATA_W-1:0] alu_op1;
   logic [DATA_W-1:0] alu_op2;
   logic [1:0]        alu_resp;
   logic [DATA_W-1:0] alu_data;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign cmd_in[g]     = req_cmd_in[g+1];
      assign dat_in[g]     = req_data_in[g+1];
      assign req[g]        = (st[g] == ST_OP2) || (st[g] == ST_WAIT);
      assign out_resp[g+1] = resp_q[g];
      assign out_data[g+1] = data_q[g];
   end

   assign pick    = rr_pick(req, ptr);
   assign gnt_any = pick[2];
   assign gnt_idx = pick[1:0];

   // A port still in OP2 feeds its second operand straight from the bus.
   assign alu_cmd = cmd_q[gnt_idx];
   assign alu_op1 = op1_q[gnt_idx];
   assign alu_op2 = (st[gnt_idx] == ST_OP2) ? dat_in[gnt_idx]
                                            : op2_q[gnt_idx];

   calc1_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .cmd  (alu_cmd),
      .op1  (alu_op1),
      .op2  (alu_op2),
      .resp (alu_resp),
      .data (alu_data)
   );

   always_ff @(posedge c_clk) begin
      if (rst) begin
         ptr <= 2'd0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            st[i]     <= ST_IDLE;
            cmd_q[i]  <= CMD_NOP;
            op1_q[i]  <= '0;
            op2_q[i]  <= '0;
            resp_q[i] <= RESP_NONE;
            data_q[i] <= '0;
         end
      end else begin
         if (gnt_any) begin
            ptr <= gnt_idx + 2'd1;
         end
         for (int i = 0; i < NUM_PORTS; i++) begin
            resp_q[i] <= RESP_NONE;
            data_q[i] <= '0;
            unique case (st[i])
               ST_IDLE: begin
                  if (cmd_in[i] != CMD_NOP) begin
                     cmd_q[i] <= cmd_in[i];
                     op1_q[i] <= dat_in[i];
                     st[i]    <= ST_OP2;
                  end
               end
               ST_OP2: begin
                  op2_q[i] <= dat_in[i];
                  if (gnt_any && gnt_idx == 2'(i)) begin
                     resp_q[i] <= alu_resp;
                     data_q[i] <= alu_data;
                     st[i]     <= ST_RESP;
                  end else begin
                     st[i] <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (gnt_any && gnt_idx == 2'(i)) begin
                     resp_q[i] <= alu_resp;
                     data_q[i] <= alu_data;
                     st[i]     <= ST_RESP;
                  end
               end
               ST_RESP: begin
                  st[i] <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_calc1_responder.sv
// Self-checking bench for calc1_responder: vector table,
// reset corner cases and randomized batches against a reference model.
module tb_calc1_responder;

   logic        c_clk = 1'b0;
   logic [1:7]  reset;
   logic [0:3]  req_cmd_in  [1:4];
   logic [0:31] req_data_in [1:4];
   logic [0:1]  out_resp    [1:4];
   logic [0:31] out_data    [1:4];

   always #5 c_clk = ~c_clk;

   calc1_responder #(
      .NUM_PORTS (4),
      .DATA_W    (32)
   ) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int last_port;

   bit          b_mask [4];
   logic [3:0]  b_cmd  [4];
   logic [31:0] b_a    [4];
   logic [31:0] b_b    [4];
   logic [1:0]  b_er   [4];
   logic [31:0] b_ed   [4];

   typedef struct {
      int          port;
      logic [3:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  er;
      logic [31:0] ed;
   } vec_t;

   vec_t vt [12];

   task automatic check(input string nm, input int p,
                        input logic [1:0] er,
                        input logic [31:0] ed);
      n_chk++;
      if (out_resp[p+1] !== er || out_data[p+1] !== ed) begin
         n_fail++;
         $display("FAIL %s port%0d t=%0t: resp=%0d data=%h, expected resp=%0d data=%h",
                  nm, p + 1, $time, out_resp[p+1], out_data[p+1], er, ed);
      end
   endtask

   function automatic void ref_calc(input logic [3:0] c,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [1:0] r,
                                    output logic [31:0] d);
      logic [63:0] s;
      r = 2'd2;
      d = 32'd0;
      case (c)
         4'd1: begin
            s = {32'd0, a} + {32'd0, b};
            if (s <= 64'hFFFF_FFFF) begin
               r = 2'd1;
               d = s[31:0];
            end
         end
         4'd2: begin
            if (b <= a) begin
               r = 2'd1;
               d = a - b;
            end
         end
         4'd5: begin
            r = 2'd1;
            d = a << (b % 32);
         end
         4'd6: begin
            r = 2'd1;
            d = a >> (b % 32);
         end
         default: ;
      endcase
   endfunction

   task automatic idle_inputs();
      for (int p = 1; p <= 4; p++) begin
         req_cmd_in[p]  = 4'd0;
         req_data_in[p] = 32'd0;
      end
   endtask

   task automatic do_reset();
      @(posedge c_clk);
      #1;
      reset = 7'b1000000;
      idle_inputs();
      repeat (2) @(posedge c_clk);
      #1;
      reset = 7'b0111111;
      last_port = 3;
   endtask

   // Issue one command per masked port in the same cycle and watch
   // every port for six cycles; each active port answers at 2 + its
   // position in round-robin order after the last served port.
   task automatic run_batch(input string nm);
      int rank [4];
      int k;
      int nl;
      k  = 0;
      nl = last_port;
      for (int i = 1; i <= 4; i++) begin
         int p;
         p = (last_port + i) % 4;
         if (b_mask[p]) begin
            rank[p] = k;
            k++;
            nl = p;
         end else begin
            rank[p] = -1;
         end
      end
      last_port = nl;
      @(posedge c_clk);
      #1;
      for (int p = 0; p < 4; p++) begin
         req_cmd_in[p+1]  = b_mask[p] ? b_cmd[p] : 4'd0;
         req_data_in[p+1] = b_mask[p] ? b_a[p] : $urandom;
      end
      for (int c = 1; c <= 6; c++) begin
         @(posedge c_clk);
         #1;
         for (int p = 0; p < 4; p++) begin
            req_data_in[p+1] = (c == 1 && b_mask[p]) ? b_b[p] : $urandom;
            if (b_mask[p] && c <= 2 + rank[p])
               req_cmd_in[p+1] = 4'($urandom_range(1, 15));
            else
               req_cmd_in[p+1] = 4'd0;
         end
         @(negedge c_clk);
         for (int p = 0; p < 4; p++) begin
            if (b_mask[p] && c == 2 + rank[p])
               check(nm, p, b_er[p], b_ed[p]);
            else
               check(nm, p, 2'd0, 32'd0);
         end
      end
      idle_inputs();
   endtask

   function automatic logic [31:0] pick_data();
      case ($urandom_range(0, 5))
         0: pick_data = 32'd0;
         1: pick_data = 32'hFFFF_FFFF;
         2: pick_data = 32'h8000_0000;
         3: pick_data = 32'($urandom_range(0, 40));
         default: pick_data = $urandom;
      endcase
   endfunction

   function automatic logic [3:0] pick_cmd();
      case ($urandom_range(0, 7))
         0, 1: pick_cmd = 4'd1;
         2, 3: pick_cmd = 4'd2;
         4: pick_cmd = 4'd5;
         5: pick_cmd = 4'd6;
         6: pick_cmd = 4'($urandom_range(3, 4));
         default: pick_cmd = 4'($urandom_range(7, 15));
      endcase
   endfunction

   initial begin
      vt[0]  = '{0, 4'd1,  32'hFFFF0000, 32'h0000FFFF, 2'd1, 32'hFFFFFFFF};
      vt[1]  = '{1, 4'd1,  32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h0};
      vt[2]  = '{2, 4'd2,  32'h80000000, 32'h00000001, 2'd1, 32'h7FFFFFFF};
      vt[3]  = '{3, 4'd2,  32'h00000000, 32'h00000001, 2'd2, 32'h0};
      vt[4]  = '{0, 4'd3,  32'h12345678, 32'h00000001, 2'd2, 32'h0};
      vt[5]  = '{1, 4'd5,  32'h00000001, 32'h0000001F, 2'd1, 32'h80000000};
      vt[6]  = '{2, 4'd6,  32'h80000000, 32'h00000020, 2'd1, 32'h80000000};
      vt[7]  = '{3, 4'd5,  32'hFFFFFFFF, 32'hFFFFFFE4, 2'd1, 32'hFFFFFFF0};
      vt[8]  = '{0, 4'd2,  32'h00000005, 32'h00000005, 2'd1, 32'h0};
      vt[9]  = '{1, 4'd15, 32'h00000001, 32'h00000001, 2'd2, 32'h0};
      vt[10] = '{2, 4'd1,  32'h7FFFFFFF, 32'h80000000, 2'd1, 32'hFFFFFFFF};
      vt[11] = '{3, 4'd4,  32'h00000001, 32'h00000002, 2'd2, 32'h0};

      reset = 7'b1000000;
      idle_inputs();
      do_reset();
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) check("reset_state", p, 2'd0, 32'd0);

      for (int v = 0; v < 12; v++) begin
         for (int p = 0; p < 4; p++) b_mask[p] = 1'b0;
         b_mask[vt[v].port] = 1'b1;
         b_cmd[vt[v].port]  = vt[v].cmd;
         b_a[vt[v].port]    = vt[v].a;
         b_b[vt[v].port]    = vt[v].b;
         b_er[vt[v].port]   = vt[v].er;
         b_ed[vt[v].port]   = vt[v].ed;
         run_batch($sformatf("vec%0d", v));
      end

      // All four ports contend right after reset: order 1,2,3,4.
      do_reset();
      for (int p = 0; p < 4; p++) begin
         b_mask[p] = 1'b1;
         b_cmd[p]  = 4'd1;
         b_a[p]    = 32'd1;
         b_b[p]    = 32'd1;
         b_er[p]   = 2'd1;
         b_ed[p]   = 32'd2;
      end
      run_batch("contend_all");

      // Reset one cycle after a command: it must vanish.
      @(posedge c_clk);
      #1;
      req_cmd_in[1]  = 4'd1;
      req_data_in[1] = 32'd5;
      @(posedge c_clk);
      #1;
      reset          = 7'b1000000;
      req_cmd_in[1]  = 4'd0;
      req_data_in[1] = 32'd6;
      req_cmd_in[2]  = 4'd1;
      req_data_in[2] = 32'd7;
      @(posedge c_clk);
      #1;
      reset = 7'b0111111;
      idle_inputs();
      last_port = 3;
      for (int c = 0; c < 6; c++) begin
         @(negedge c_clk);
         for (int p = 0; p < 4; p++) check("reset_abandon", p, 2'd0, 32'd0);
         @(posedge c_clk);
      end
      for (int p = 0; p < 4; p++) b_mask[p] = 1'b0;
      b_mask[0] = 1'b1;
      b_cmd[0]  = 4'd1;
      b_a[0]    = 32'd2;
      b_b[0]    = 32'd3;
      b_er[0]   = 2'd1;
      b_ed[0]   = 32'd5;
      run_batch("after_reset");

      for (int n = 0; n < 60; n++) begin
         logic [3:0] m;
         m = 4'($urandom_range(1, 15));
         for (int p = 0; p < 4; p++) begin
            b_mask[p] = m[p];
            b_cmd[p]  = pick_cmd();
            b_a[p]    = pick_data();
            b_b[p]    = pick_data();
            ref_calc(b_cmd[p], b_a[p], b_b[p], b_er[p], b_ed[p]);
         end
         run_batch($sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
